// File: rtl/bank_mem.sv
`default_nettype none
// ============================================================================
// Module   : bank_mem
// Brief    : Byte-addressed little-endian memory with a request/response
//            handshake, RD_LAT-cycle response pipeline and in-order output
//            queue. Define BANK_MEM_MISALIGN_ERR_EN to reject misaligned
//            halfword/word accesses.
// Revision : 1.0 - initial release
// ============================================================================
module bank_mem #(
    parameter int DEPTH_BYTES = 1024,
    parameter int RD_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int c_AW = $clog2(DEPTH_BYTES);
    localparam int c_QD = RD_LAT + 1;
    localparam int c_PW = $clog2(c_QD);
    localparam int c_CW = $clog2(c_QD + 1);

    logic [7:0]       r_mem [DEPTH_BYTES];
    logic [31:0]      r_q_data [c_QD];
    logic [c_QD-1:0]  r_q_err;
    logic [c_PW-1:0]  r_wp;
    logic [c_PW-1:0]  r_rp;
    logic [c_CW-1:0]  r_qcnt;
    logic [c_CW-1:0]  r_out;

    logic             w_accept;
    logic             w_consume;
    logic             w_wr;
    logic [2:0]       w_nbytes;
    logic [32:0]      w_last;
    logic             w_oor;
    logic             w_mis;
    logic             w_err;
    logic [c_AW-1:0]  w_idx [4];
    logic [31:0]      w_raw;
    logic             w_sx;
    logic [31:0]      w_rsp_data;
    logic             w_push;
    logic [31:0]      w_push_data;
    logic             w_push_err;

    function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
        return (p == c_PW'(c_QD - 1)) ? '0 : p + c_PW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Request decode and error classification
    // ------------------------------------------------------------------
    always_comb begin
        w_nbytes = 3'd4;
        case (req_size)
            2'b00:   w_nbytes = 3'd1;
            2'b01:   w_nbytes = 3'd2;
            default: w_nbytes = 3'd4;
        endcase
    end

    // 33-bit end address so that addresses near 2^32 cannot wrap into range
    assign w_last = {1'b0, req_addr} + {30'd0, w_nbytes} - 33'd1;
    assign w_oor  = (w_last >= 33'(DEPTH_BYTES));

`ifdef BANK_MEM_MISALIGN_ERR_EN
    assign w_mis = ((req_size == 2'b01) & req_addr[0]) |
                   ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
`else
    assign w_mis = 1'b0;
`endif

    assign w_err     = (req_size == 2'b11) | w_oor | w_mis;
    assign w_accept  = req_valid & req_ready;
    assign w_consume = rsp_valid & rsp_ready;
    assign w_wr      = w_accept & req_we & ~w_err;

    // Byte lane indices; wrap inside the array only matters for error cases
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_idx[k] = req_addr[c_AW-1:0] + c_AW'(k);
        end
    end

    assign w_raw = {r_mem[w_idx[3]], r_mem[w_idx[2]], r_mem[w_idx[1]], r_mem[w_idx[0]]};
    assign w_sx  = ~req_unsigned;

    always_comb begin
        w_rsp_data = '0;
        if (!req_we && !w_err) begin
            case (req_size)
                2'b00:   w_rsp_data = {{24{w_sx & w_raw[7]}}, w_raw[7:0]};
                2'b01:   w_rsp_data = {{16{w_sx & w_raw[15]}}, w_raw[15:0]};
                2'b10:   w_rsp_data = w_raw;
                default: w_rsp_data = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage: not reset, written only by accepted legal stores
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < w_nbytes) begin
                    r_mem[w_idx[k]] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response latency pipeline
    // ------------------------------------------------------------------
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic        r_p_vld;
            logic [31:0] r_p_data;
            logic        r_p_err;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_p_vld  <= 1'b0;
                    r_p_data <= '0;
                    r_p_err  <= 1'b0;
                end else begin
                    r_p_vld  <= w_accept;
                    r_p_data <= w_rsp_data;
                    r_p_err  <= w_accept & w_err;
                end
            end

            assign w_push      = r_p_vld;
            assign w_push_data = r_p_data;
            assign w_push_err  = r_p_err;
        end else begin : g_lat1
            assign w_push      = w_accept;
            assign w_push_data = w_rsp_data;
            assign w_push_err  = w_err;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output queue and outstanding counter; r_out bounds r_qcnt so the
    // queue can never overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_q_data[r_wp] <= w_push_data;
            r_q_err[r_wp]  <= w_push_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_qcnt <= '0;
            r_out  <= '0;
        end else begin
            if (w_push) begin
                r_wp <= f_next(r_wp);
            end
            if (w_consume) begin
                r_rp <= f_next(r_rp);
            end
            case ({w_push, w_consume})
                2'b10:   r_qcnt <= r_qcnt + c_CW'(1);
                2'b01:   r_qcnt <= r_qcnt - c_CW'(1);
                default: r_qcnt <= r_qcnt;
            endcase
            case ({w_accept, w_consume})
                2'b10:   r_out <= r_out + c_CW'(1);
                2'b01:   r_out <= r_out - c_CW'(1);
                default: r_out <= r_out;
            endcase
        end
    end

    assign rsp_valid = ~rst & (r_qcnt != '0);
    assign rsp_rdata = rsp_valid ? r_q_data[r_rp] : '0;
    assign rsp_err   = rsp_valid & r_q_err[r_rp];
    assign req_ready = ~rst & ((r_out < c_CW'(c_QD)) | (rsp_valid & rsp_ready));

endmodule
`default_nettype wire

// File: tb/tb_bank_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_mem
// Brief    : Directed and randomized bench for bank_mem (RD_LAT=2) with a
//            byte-array reference model and in-order response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bank_mem;

    localparam int D = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    bank_mem #(.DEPTH_BYTES(D), .RD_LAT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_rsp    = 0;
    bit          rnd_rdy  = 1'b0;
    bit [7:0]    m [D];
    logic [31:0] exp_d [$];
    bit          exp_e [$];
    logic [31:0] last_rdata;
    logic        last_err;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte array, sizes and extension from plain arithmetic
    function automatic void model(input bit we, input bit [1:0] sz, input bit uns,
                                  input bit [31:0] a, input bit [31:0] wd,
                                  output logic [31:0] rd, output bit er);
        int          nb;
        longint      last;
        logic [31:0] v;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        last = longint'({32'd0, a}) + nb - 1;
        er   = (sz == 2'd3) || (last >= D);
`ifdef BANK_MEM_MISALIGN_ERR_EN
        if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) er = 1'b1;
`endif
        rd = '0;
        if (!er && !we) begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (32'(m[int'(a) + i]) << (8 * i));
            if (!uns && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            rd = v;
        end
        if (!er && we) begin
            for (int i = 0; i < nb; i++) m[int'(a) + i] = wd[8*i +: 8];
        end
    endfunction

    // Scoreboard: in-order compare on each handshake, plus hold-stable check
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(rsp_valid), 1);
                check("hold_rdata", rsp_rdata, prev_data);
                check("hold_err", 32'(rsp_err), 32'(prev_err));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_d.size() == 0) begin
                    check("rsp_unexpected", 32'(exp_d.size()), 1);
                end else begin
                    check("rsp_rdata", rsp_rdata, exp_d.pop_front());
                    check("rsp_err", 32'(rsp_err), 32'(exp_e.pop_front()));
                end
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
                n_rsp++;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_rdata;
            prev_err   = rsp_err;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called and returns at posedge+1; holds the request until accepted
    task automatic send(input bit we, input bit [1:0] sz, input bit uns,
                        input bit [31:0] a, input bit [31:0] wd);
        int          cyc;
        bit          done;
        logic [31:0] rd;
        bit          er;
        cyc  = 0;
        done = 1'b0;
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1'b1;
            end else begin
                cyc++;
                if (cyc > 200) begin
                    check("req_accept_timeout", 32'(req_ready), 1);
                    $display("FAIL req_accept_timeout: request never accepted");
                    $fatal(1, "request never accepted");
                end
            end
            step();
            if (!done && rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
        end
        model(we, sz, uns, a, wd, rd, er);
        exp_d.push_back(rd);
        exp_e.push_back(er);
        req_valid = 1'b0;
        if (rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        rsp_ready = 1'b1;
        while (exp_d.size() != 0 && cyc < 500) begin
            step();
            cyc++;
        end
        check("drain_empty", 32'(exp_d.size()), 0);
    endtask

    initial begin
        int          n0;
        logic [31:0] e;
        bit [31:0]   a;
        bit [1:0]    sz;
        int          sel;

        // Reset behaviour
        repeat (2) begin
            @(negedge clk);
            check("rst_req_ready", 32'(req_ready), 0);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_rsp_err", 32'(rsp_err), 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 1);
        step();

        // Known contents everywhere
        for (int i = 0; i < D / 4; i++) send(1'b1, 2'b10, 1'b0, 32'(4 * i), $urandom());
        drain();

        // Word store then byte / halfword loads
        send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        send(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        drain();
        check("byte_signed_rdata", last_rdata, 32'hFFFF_FFDE);
        check("byte_signed_err", 32'(last_err), 0);
        send(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        drain();
        check("half_unsigned", last_rdata, 32'h0000_BEEF);
        send(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        drain();
        check("half_signed", last_rdata, 32'hFFFF_BEEF);

        // Latency: response appears exactly two cycles after accept
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        check("lat_not_yet", 32'(rsp_valid), 0);
        step();
        @(negedge clk);
        check("lat_visible", 32'(rsp_valid), 1);
        step();
        drain();

        // Back-pressure: three loads fill the queue
        rsp_ready = 1'b0;
        n0 = n_rsp;
        send(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        send(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        send(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
        @(negedge clk);
        check("bp_ready_low", 32'(req_ready), 0);
        check("bp_rsp_valid", 32'(rsp_valid), 1);
        step();
        step();
        drain();
        check("bp_rsp_count", 32'(n_rsp - n0), 3);

        // Out-of-range at the top of the array
        send(1'b0, 2'b10, 1'b0, 32'(D - 2), 32'h0);
        drain();
        check("oor_load_err", 32'(last_err), 1);
        check("oor_load_rdata", last_rdata, 0);
        e = {16'd0, m[D-1], m[D-2]};
        send(1'b1, 2'b10, 1'b0, 32'(D - 2), 32'hA5A5_A5A5);
        drain();
        check("oor_store_err", 32'(last_err), 1);
        send(1'b0, 2'b01, 1'b1, 32'(D - 2), 32'h0);
        drain();
        check("oor_store_nowrite", last_rdata, e);
        send(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'h0);
        drain();
        check("no_wrap_err", 32'(last_err), 1);

        // Misaligned word store
        e = {m[32'h24], m[32'h23], m[32'h22], m[32'h21]};
        send(1'b1, 2'b10, 1'b0, 32'h21, 32'h1122_3344);
        drain();
`ifdef BANK_MEM_MISALIGN_ERR_EN
        check("misalign_err", 32'(last_err), 1);
`else
        check("misalign_err", 32'(last_err), 0);
        e = 32'h1122_3344;
`endif
        send(1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
        drain();
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 2'b00, 1'b1, 32'(32'h21 + i), 32'h0);
            drain();
            check("misalign_byte", last_rdata, {24'd0, e[8*i +: 8]});
        end

        // Reset with two responses pending; store under reset is dropped
        rsp_ready = 1'b0;
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        send(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        rst = 1'b1;
        exp_d.delete();
        exp_e.delete();
        e = {m[32'h43], m[32'h42], m[32'h41], m[32'h40]};
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = 32'h40; req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("rst_flush_valid", 32'(rsp_valid), 0);
        check("rst_flush_ready", 32'(req_ready), 0);
        step();
        step();
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 32'(rsp_valid), 0);
        check("post_rst_ready", 32'(req_ready), 1);
        step();
        send(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
        drain();
        check("post_rst_data", last_rdata, 32'hDEAD_BEEF);
        send(1'b0, 2'b10, 1'b1, 32'h40, 32'h0);
        drain();
        check("rst_store_dropped", last_rdata, e);

        // Randomized traffic with random back-pressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = 32'(D - int'($urandom_range(1, 4)));
            else if (sel == 1) a = $urandom();
            else               a = 32'($urandom_range(0, D - 1));
            sz = 2'($urandom_range(0, 3));
            send(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
        end
        rnd_rdy = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
